// File: rtl/mor1kx_decode_execute_hazard_pkg.sv
// Shared types and constants for the decode/execute pipeline register.
// Used by mor1kx_decode_execute_hazard and mor1kx_hazard_detect.
package mor1kx_decode_execute_hazard_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  // Bit positions inside the packed op-flag vector
  localparam int unsigned OP_W     = 7;
  localparam int unsigned OP_LOAD  = 0;
  localparam int unsigned OP_STORE = 1;
  localparam int unsigned OP_MFSPR = 2;
  localparam int unsigned OP_MTSPR = 3;
  localparam int unsigned OP_JAL   = 4;
  localparam int unsigned OP_JR    = 5;
  localparam int unsigned OP_RFE   = 6;

  // Bit positions inside the exception vector
  localparam int unsigned EXC_W        = 4;
  localparam int unsigned EXC_IBUS_ERR = 0;
  localparam int unsigned EXC_ILLEGAL  = 1;
  localparam int unsigned EXC_SYSCALL  = 2;
  localparam int unsigned EXC_TRAP     = 3;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

endpackage

// File: rtl/mor1kx_hazard_detect.sv
// Combinational load-use / mfspr-use hazard detection against the execute stage.
module mor1kx_hazard_detect
  import mor1kx_decode_execute_hazard_pkg::*;
#(
  parameter int unsigned RF_ADDR_WIDTH = 5
) (
  input  logic                     decode_bubble_i,
  input  logic                     exec_load_i,
  input  logic                     exec_mfspr_i,
  input  logic                     exec_rf_wb_i,
  input  logic [RF_ADDR_WIDTH-1:0] exec_rfd_adr_i,
  input  logic                     rfa_used_i,
  input  logic [RF_ADDR_WIDTH-1:0] rfa_adr_i,
  input  logic                     rfb_used_i,
  input  logic [RF_ADDR_WIDTH-1:0] rfb_adr_i,
  output logic                     stall_o
);

  logic late_result;
  logic src_match;

  // r0 is hardwired zero, so a write to it can never be a dependency
  assign late_result = (exec_load_i | exec_mfspr_i) & exec_rf_wb_i &
                       (exec_rfd_adr_i != '0);
  assign src_match   = (rfa_used_i & (rfa_adr_i == exec_rfd_adr_i)) |
                       (rfb_used_i & (rfb_adr_i == exec_rfd_adr_i));
  assign stall_o     = !decode_bubble_i & late_result & src_match;

endmodule

// File: rtl/mor1kx_decode_execute_hazard.sv
// Decode-to-execute pipeline register with bubble insertion on load/mfspr-use hazards.
// Optional MOR1KX_HAZARD_COUNT_EN adds a saturating count of inserted bubbles.
module mor1kx_decode_execute_hazard
  import mor1kx_decode_execute_hazard_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
  parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC = OPTION_OPERAND_WIDTH'(RESET_PC)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic                            padv_execute_i,
  input  logic                            pipeline_flush_i,
  input  logic                            decode_bubble_i,
  input  logic                            decode_op_load_i,
  input  logic                            decode_op_store_i,
  input  logic                            decode_op_mfspr_i,
  input  logic                            decode_op_mtspr_i,
  input  logic                            decode_op_jal_i,
  input  logic                            decode_op_jr_i,
  input  logic                            decode_op_rfe_i,
  input  logic                            decode_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfb_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfd_adr_i,
  input  logic                            decode_rfa_used_i,
  input  logic                            decode_rfb_used_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_imm_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pc_decode_i,
  input  logic                            decode_except_ibus_err_i,
  input  logic                            decode_except_illegal_i,
  input  logic                            decode_except_syscall_i,
  input  logic                            decode_except_trap_i,
  output logic                            execute_op_load_o,
  output logic                            execute_op_store_o,
  output logic                            execute_op_mfspr_o,
  output logic                            execute_op_mtspr_o,
  output logic                            execute_op_jal_o,
  output logic                            execute_op_jr_o,
  output logic                            execute_op_rfe_o,
  output logic                            execute_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] execute_rfa_adr_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] execute_rfb_adr_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] execute_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] execute_imm_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] pc_execute_o,
  output logic                            execute_except_ibus_err_o,
  output logic                            execute_except_illegal_o,
  output logic                            execute_except_syscall_o,
  output logic                            execute_except_trap_o,
  output logic                            execute_bubble_o,
`ifdef MOR1KX_HAZARD_COUNT_EN
  output logic [31:0]                     hazard_bubble_cnt_o,
`endif
  output logic                            decode_stall_o
);

  state_e                          state_q, state_d;
  logic [OP_W-1:0]                 ops_q, ops_d;
  logic [EXC_W-1:0]                exc_q, exc_d;
  logic                            wb_q, wb_d;
  logic                            bubble_q, bubble_d;
  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_q, rfa_d, rfb_q, rfb_d, rfd_q, rfd_d;
  logic [OPTION_OPERAND_WIDTH-1:0] imm_q, imm_d, pc_q, pc_d;
  logic                            stall;
  logic                            capture;
  logic                            insert;
  logic [OP_W-1:0]                 dec_ops;
  logic [EXC_W-1:0]                dec_exc;

  mor1kx_hazard_detect #(
    .RF_ADDR_WIDTH (OPTION_RF_ADDR_WIDTH)
  ) u_hazard_detect (
    .decode_bubble_i (decode_bubble_i),
    .exec_load_i     (ops_q[OP_LOAD]),
    .exec_mfspr_i    (ops_q[OP_MFSPR]),
    .exec_rf_wb_i    (wb_q),
    .exec_rfd_adr_i  (rfd_q),
    .rfa_used_i      (decode_rfa_used_i),
    .rfa_adr_i       (decode_rfa_adr_i),
    .rfb_used_i      (decode_rfb_used_i),
    .rfb_adr_i       (decode_rfb_adr_i),
    .stall_o         (stall)
  );

  assign dec_ops = {decode_op_rfe_i, decode_op_jr_i, decode_op_jal_i, decode_op_mtspr_i,
                    decode_op_mfspr_i, decode_op_store_i, decode_op_load_i};
  assign dec_exc = {decode_except_trap_i, decode_except_syscall_i,
                    decode_except_illegal_i, decode_except_ibus_err_i};

  assign capture = padv_decode_i & !stall;
  assign insert  = (state_q == ST_RUN) & padv_execute_i & stall;

`ifdef MOR1KX_HAZARD_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = (insert && !pipeline_flush_i && cnt_q != CNT_MAX) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign hazard_bubble_cnt_o = cnt_q;
`endif

  // Next-state: flush beats bubble insertion beats capture; everything else holds
  always_comb begin
    state_d  = state_q;
    ops_d    = ops_q;
    exc_d    = exc_q;
    wb_d     = wb_q;
    bubble_d = bubble_q;
    rfa_d    = rfa_q;
    rfb_d    = rfb_q;
    rfd_d    = rfd_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    if (pipeline_flush_i || insert) begin
      ops_d    = '0;
      exc_d    = '0;
      wb_d     = 1'b0;
      bubble_d = 1'b1;
      state_d  = pipeline_flush_i ? ST_RUN : ST_BUBBLE;
    end else begin
      state_d = ST_RUN;
      if (capture) begin
        ops_d    = dec_ops;
        exc_d    = dec_exc;
        wb_d     = decode_rf_wb_i;
        bubble_d = decode_bubble_i;
        rfa_d    = decode_rfa_adr_i;
        rfb_d    = decode_rfb_adr_i;
        rfd_d    = decode_rfd_adr_i;
        imm_d    = decode_imm_i;
        if (!decode_bubble_i) pc_d = pc_decode_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      ops_q    <= '0;
      exc_q    <= '0;
      wb_q     <= 1'b0;
      bubble_q <= 1'b1;
      rfa_q    <= '0;
      rfb_q    <= '0;
      rfd_q    <= '0;
      imm_q    <= '0;
      pc_q     <= OPTION_RESET_PC;
    end else begin
      state_q  <= state_d;
      ops_q    <= ops_d;
      exc_q    <= exc_d;
      wb_q     <= wb_d;
      bubble_q <= bubble_d;
      rfa_q    <= rfa_d;
      rfb_q    <= rfb_d;
      rfd_q    <= rfd_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
    end
  end

  assign execute_op_load_o         = ops_q[OP_LOAD];
  assign execute_op_store_o        = ops_q[OP_STORE];
  assign execute_op_mfspr_o        = ops_q[OP_MFSPR];
  assign execute_op_mtspr_o        = ops_q[OP_MTSPR];
  assign execute_op_jal_o          = ops_q[OP_JAL];
  assign execute_op_jr_o           = ops_q[OP_JR];
  assign execute_op_rfe_o          = ops_q[OP_RFE];
  assign execute_rf_wb_o           = wb_q;
  assign execute_rfa_adr_o         = rfa_q;
  assign execute_rfb_adr_o         = rfb_q;
  assign execute_rfd_adr_o         = rfd_q;
  assign execute_imm_o             = imm_q;
  assign pc_execute_o              = pc_q;
  assign execute_except_ibus_err_o = exc_q[EXC_IBUS_ERR];
  assign execute_except_illegal_o  = exc_q[EXC_ILLEGAL];
  assign execute_except_syscall_o  = exc_q[EXC_SYSCALL];
  assign execute_except_trap_o     = exc_q[EXC_TRAP];
  assign execute_bubble_o          = bubble_q;
  assign decode_stall_o            = stall;

endmodule
